ghost_controller: RTL and testbench
===================================

Name: ghost_controller

Overview:
- Parametrised movement engine for NUM_GHOSTS ghosts. Replaces the fixed per-ghost position registers in the game top level.
- On each movement tick, updates every ghost's position and direction in sequence, one ghost per clock.
- At tile-aligned positions, a ghost picks its direction by chase or flee distance to the player, subject to the wall tilemap.
- Outputs feed the renderer (positions, directions) and game logic (per-ghost collision flags).

Parameters:
NUM_GHOSTS, 4, number of ghosts (1..8)
X_W, 10, pixel x coordinate width
Y_W, 9, pixel y coordinate width
TILE_SHIFT, 4, log2 of tile size in pixels (16 px tiles)
TILE_COLS, 40, tilemap columns
TILE_ROWS, 30, tilemap rows
HOME_X, 272, reset x of ghost 0; ghost g resets at HOME_X + g*2*(1<<TILE_SHIFT)
HOME_Y, 224, reset y of every ghost

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle movement strobe
flee  in  1  0 = chase the player, 1 = flee from the player (sampled at tick)
player_x  in  X_W  player pixel x (sampled at tick)
player_y  in  Y_W  player pixel y (sampled at tick)
tilemap_walls  in  TILE_ROWS*TILE_COLS  wall bit; index = row*TILE_COLS+col
ghost_x  out  NUM_GHOSTS*X_W  packed x; ghost g occupies [g*X_W +: X_W]
ghost_y  out  NUM_GHOSTS*Y_W  packed y
ghost_dir  out  NUM_GHOSTS*2  packed direction: 0 up, 1 down, 2 left, 3 right
collide  out  NUM_GHOSTS  ghost g overlaps the player
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse when a sweep ends

Behaviour:
- Reset (async, active-high) drives all outputs to their reset values:
  - ghost g: x = HOME_X + g*2*(1<<TILE_SHIFT), y = HOME_Y, dir = up.
  - collide = 0, busy = 0, done = 0, FSM = IDLE, g = 0.
- FSM states: IDLE, EVAL, FIN.
  - IDLE: tick=1 → latch flee, player_x, player_y; g ← 0; → EVAL; busy ← 1.
  - EVAL: process ghost g in one cycle. If g == NUM_GHOSTS-1 → FIN, else g ← g+1.
  - FIN: update collide for all ghosts; done ← 1 for this cycle only; busy ← 0; → IDLE.
- Latency: tick at cycle T → done high at T+NUM_GHOSTS+1. Positions are updated in the cycle after each ghost's EVAL.
- A tick that arrives while busy is ignored. The sweep is not restarted and nothing is queued.
- Per-ghost update in EVAL:
  - A ghost is aligned when x[TILE_SHIFT-1:0] == 0 and y[TILE_SHIFT-1:0] == 0.
  - Not aligned: keep dir and move 1 px in dir. No wall check is needed, because the ghost is already committed to the next tile.
  - Aligned:
    - Candidate order is up, left, down, right. The reverse of the current dir is excluded.
    - A candidate is blocked if its neighbour tile is a wall or outside the map (row<0, row≥TILE_ROWS, col<0, col≥TILE_COLS).
    - Cost of a candidate = |nx-px| + |ny-py| in tiles, where nx/ny is the neighbour tile and px/py is the latched player position >>TILE_SHIFT. Compute with X_W+1 / Y_W+1 bit signed differences; no wrap-around.
    - flee=0 picks the minimum cost; flee=1 picks the maximum. Ties go to the earlier candidate in order.
    - If all non-reverse candidates are blocked, take the reverse. If the reverse is also blocked, dir is unchanged and the ghost does not move.
    - Otherwise set the new dir and move 1 px.
- Collision (in FIN): collide[g] = 1 when |gx-player_x| < (1<<TILE_SHIFT) and |gy-player_y| < (1<<TILE_SHIFT), using the latched player position.
- Reset mid-sweep: positions already written keep no value; every ghost returns to its reset state and busy/done drop immediately.
- tilemap_walls is read combinationally in EVAL. Changes during a sweep are allowed; each ghost sees the map as it is in its own EVAL cycle.

Test Plan:
1. Reset with NUM_GHOSTS=4 → ghost_x = {368,336,304,272} (g3..g0), all y = 224, dirs = 0, collide = 0, busy = 0.
2. Ghost 0 at (272,225) moving down, tick → busy for 5 cycles; done on the 5th; ghost 0 at (272,226), dir still down.
3. Ghost 0 aligned at (160,160) dir right, walls at tile (10,11) right and tile (9,10) up, player at (160,320), flee=0, tick → dir down, y = 161.
4. Same setup with flee=1 → left is excluded as the reverse, right and up are blocked, so down is the only candidate: dir down. Then clear the up wall and repeat → dir up, y = 159.
5. Ghost 0 in a dead end with only the reverse open, tick → dir reversed, moved 1 px. Fully boxed in → position and dir unchanged.
6. tick on the cycle after a tick → ignored, exactly one done pulse. Assert reset during EVAL g=2 → all ghosts at reset values next cycle, busy = 0. Player at ghost 1's position + (15,0) → collide = 0010 after done.

Source files
------------

// File: rtl/ghost_controller.sv
// Ghost movement engine: one ghost per clock per tick, tile-aligned chase/flee steering.
module ghost_controller #(
    parameter int unsigned NUM_GHOSTS = 4,
    parameter int unsigned X_W        = 10,
    parameter int unsigned Y_W        = 9,
    parameter int unsigned TILE_SHIFT = 4,
    parameter int unsigned TILE_COLS  = 40,
    parameter int unsigned TILE_ROWS  = 30,
    parameter int unsigned HOME_X     = 272,
    parameter int unsigned HOME_Y     = 224
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           tick,
    input  logic                           flee,
    input  logic [X_W-1:0]                 player_x,
    input  logic [Y_W-1:0]                 player_y,
    input  logic [TILE_ROWS*TILE_COLS-1:0] tilemap_walls,
    output logic [NUM_GHOSTS*X_W-1:0]      ghost_x,
    output logic [NUM_GHOSTS*Y_W-1:0]      ghost_y,
    output logic [NUM_GHOSTS*2-1:0]        ghost_dir,
    output logic [NUM_GHOSTS-1:0]          collide,
    output logic                           busy,
    output logic                           done
);
    localparam int unsigned MAP_W   = TILE_ROWS * TILE_COLS;
    localparam int unsigned IDX_W   = $clog2(MAP_W);
    localparam int unsigned G_W     = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int unsigned COST_W  = ((X_W > Y_W) ? X_W : Y_W) + 1;
    localparam int unsigned TILE_PX = 1 << TILE_SHIFT;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_FIN} state_t;

    state_t                state_q, state_d;
    logic [G_W-1:0]        idx_q, idx_d;
    logic                  flee_q, flee_d;
    logic [X_W-1:0]        px_q, px_d;
    logic [Y_W-1:0]        py_q, py_d;
    logic [X_W-1:0]        gx_q [NUM_GHOSTS];
    logic [X_W-1:0]        gx_d [NUM_GHOSTS];
    logic [Y_W-1:0]        gy_q [NUM_GHOSTS];
    logic [Y_W-1:0]        gy_d [NUM_GHOSTS];
    logic [1:0]            gdir_q [NUM_GHOSTS];
    logic [1:0]            gdir_d [NUM_GHOSTS];
    logic [NUM_GHOSTS-1:0] collide_q, collide_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [X_W-1:0]    cur_x, col_t, pcol_t, nxt_x;
    logic [Y_W-1:0]    cur_y, row_t, prow_t, nxt_y;
    logic [1:0]        cur_dir, rev_dir, best_dir, new_dir, cand, kk;
    logic              aligned, in_map, found, step;
    logic [X_W-1:0]    nb_col  [4];
    logic [Y_W-1:0]    nb_row  [4];
    logic [IDX_W-1:0]  nb_idx  [4];
    logic [COST_W-1:0] nb_cost [4];
    logic [COST_W-1:0] best_cost;
    logic [3:0]        nb_blk;

    function automatic logic [X_W-1:0] absdiff_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [Y_W-1:0] absdiff_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Neighbour tiles of the ghost under evaluation: blocked flag and player distance.
    // Off-map neighbours wrap to large unsigned values and so fail the range test.
    always_comb begin
        cur_x   = gx_q[idx_q];
        cur_y   = gy_q[idx_q];
        cur_dir = gdir_q[idx_q];
        aligned = (cur_x[TILE_SHIFT-1:0] == '0) && (cur_y[TILE_SHIFT-1:0] == '0);
        col_t   = cur_x >> TILE_SHIFT;
        row_t   = cur_y >> TILE_SHIFT;
        pcol_t  = px_q >> TILE_SHIFT;
        prow_t  = py_q >> TILE_SHIFT;
        rev_dir = {cur_dir[1], ~cur_dir[0]};
        in_map  = 1'b0;
        nb_blk  = '0;
        for (int d = 0; d < 4; d++) begin
            nb_col[d] = col_t;
            nb_row[d] = row_t;
            case (2'(d))
                DIR_UP:   nb_row[d] = row_t - Y_W'(1);
                DIR_DOWN: nb_row[d] = row_t + Y_W'(1);
                DIR_LEFT: nb_col[d] = col_t - X_W'(1);
                default:  nb_col[d] = col_t + X_W'(1);
            endcase
            in_map     = (nb_col[d] < X_W'(TILE_COLS)) && (nb_row[d] < Y_W'(TILE_ROWS));
            nb_idx[d]  = in_map ? (IDX_W'(nb_row[d]) * IDX_W'(TILE_COLS) + IDX_W'(nb_col[d])) : '0;
            nb_blk[d]  = !in_map || tilemap_walls[nb_idx[d]];
            nb_cost[d] = COST_W'(absdiff_x(nb_col[d], pcol_t)) + COST_W'(absdiff_y(nb_row[d], prow_t));
        end
    end

    // Direction choice in up/left/down/right order, then the 1 px step.
    always_comb begin
        found     = 1'b0;
        best_dir  = cur_dir;
        best_cost = '0;
        kk        = '0;
        cand      = '0;
        for (int k = 0; k < 4; k++) begin
            kk   = 2'(k);
            cand = {kk[0], kk[1]};
            if ((cand != rev_dir) && !nb_blk[cand]) begin
                if (!found || (flee_q ? (nb_cost[cand] > best_cost) : (nb_cost[cand] < best_cost))) begin
                    found     = 1'b1;
                    best_dir  = cand;
                    best_cost = nb_cost[cand];
                end
            end
        end
        new_dir = cur_dir;
        step    = 1'b1;
        if (aligned) begin
            if (found)                new_dir = best_dir;
            else if (!nb_blk[rev_dir]) new_dir = rev_dir;
            else                      step    = 1'b0;
        end
        nxt_x = cur_x;
        nxt_y = cur_y;
        if (step) begin
            case (new_dir)
                DIR_UP:   nxt_y = cur_y - Y_W'(1);
                DIR_DOWN: nxt_y = cur_y + Y_W'(1);
                DIR_LEFT: nxt_x = cur_x - X_W'(1);
                default:  nxt_x = cur_x + X_W'(1);
            endcase
        end
    end

    // Sweep FSM: next state, ghost updates and status outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        flee_d    = flee_q;
        px_d      = px_q;
        py_d      = py_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        gdir_d    = gdir_q;
        collide_d = collide_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    flee_d  = flee;
                    px_d    = player_x;
                    py_d    = player_y;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                gx_d[idx_q]   = nxt_x;
                gy_d[idx_q]   = nxt_y;
                gdir_d[idx_q] = new_dir;
                if (idx_q == G_W'(NUM_GHOSTS - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    idx_d = idx_q + G_W'(1);
                end
            end
            S_FIN: begin
                for (int g = 0; g < NUM_GHOSTS; g++) begin
                    collide_d[g] = (absdiff_x(gx_q[g], px_q) < X_W'(TILE_PX)) &&
                                   (absdiff_y(gy_q[g], py_q) < Y_W'(TILE_PX));
                end
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and ghost registers; ghosts return home on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            flee_q    <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
            collide_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int g = 0; g < NUM_GHOSTS; g++) begin
                gx_q[g]   <= X_W'(HOME_X + (2 * TILE_PX) * unsigned'(g));
                gy_q[g]   <= Y_W'(HOME_Y);
                gdir_q[g] <= DIR_UP;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            flee_q    <= flee_d;
            px_q      <= px_d;
            py_q      <= py_d;
            collide_q <= collide_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            gdir_q    <= gdir_d;
        end
    end

    // Pack per-ghost registers onto the output buses.
    always_comb begin
        ghost_x   = '0;
        ghost_y   = '0;
        ghost_dir = '0;
        for (int g = 0; g < NUM_GHOSTS; g++) begin
            ghost_x[g*X_W +: X_W] = gx_q[g];
            ghost_y[g*Y_W +: Y_W] = gy_q[g];
            ghost_dir[g*2 +: 2]   = gdir_q[g];
        end
    end

    assign collide = collide_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ghost_controller.sv
// Self-checking bench for ghost_controller: collision vector table, hand corner cases,
// and random sweeps against an integer reference model of the steering rules.
module tb_ghost_controller;
    localparam int NG = 4;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int TC = 40;
    localparam int TR = 30;
    localparam int HX = 272;
    localparam int HY = 224;

    logic             clk = 1'b0;
    logic             reset, tick, flee;
    logic [XW-1:0]    player_x;
    logic [YW-1:0]    player_y;
    logic [TR*TC-1:0] walls;
    logic [NG*XW-1:0] ghost_x;
    logic [NG*YW-1:0] ghost_y;
    logic [NG*2-1:0]  ghost_dir;
    logic [NG-1:0]    collide;
    logic             busy, done;

    always #5 clk = ~clk;

    ghost_controller #(.NUM_GHOSTS(NG)) dut (
        .clk(clk), .reset(reset), .tick(tick), .flee(flee),
        .player_x(player_x), .player_y(player_y), .tilemap_walls(walls),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_dir(ghost_dir),
        .collide(collide), .busy(busy), .done(done)
    );

    typedef struct { int px; int py; logic [NG-1:0] exp_col; } col_vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int mx [NG];
    int my [NG];
    int md [NG];
    int lat_px, lat_py;
    int DX  [4] = '{0, 0, -1, 1};
    int DY  [4] = '{-1, 1, 0, 0};
    int ORD [4] = '{0, 2, 1, 3};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic bit wall_at(input int r, input int c);
        if (r < 0 || r >= TR || c < 0 || c >= TC) return 1'b1;
        return walls[r*TC + c];
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NG; g++) begin
            mx[g] = HX + g * 32;
            my[g] = HY;
            md[g] = 0;
        end
    endtask

    // One sweep of the movement rules using whole-number tile arithmetic.
    task automatic model_sweep(input bit fl, input int px, input int py);
        int tc, tr, rev, best, bc, cost, d;
        for (int g = 0; g < NG; g++) begin
            if ((mx[g] % 16) != 0 || (my[g] % 16) != 0) begin
                mx[g] += DX[md[g]];
                my[g] += DY[md[g]];
            end else begin
                tc = mx[g] / 16; tr = my[g] / 16;
                rev = md[g] ^ 1; best = -1; bc = 0;
                for (int k = 0; k < 4; k++) begin
                    d = ORD[k];
                    if (d != rev && !wall_at(tr + DY[d], tc + DX[d])) begin
                        cost = iabs(tc + DX[d] - px / 16) + iabs(tr + DY[d] - py / 16);
                        if (best < 0 || (fl ? (cost > bc) : (cost < bc))) begin
                            best = d; bc = cost;
                        end
                    end
                end
                if (best < 0 && !wall_at(tr + DY[rev], tc + DX[rev])) best = rev;
                if (best >= 0) begin
                    md[g] = best;
                    mx[g] += DX[best];
                    my[g] += DY[best];
                end
            end
        end
    endtask

    task automatic chk_model(input string tag);
        logic [NG*XW-1:0] ex;
        logic [NG*YW-1:0] ey;
        logic [NG*2-1:0]  ed;
        logic [NG-1:0]    ec;
        for (int g = 0; g < NG; g++) begin
            ex[g*XW +: XW] = XW'(mx[g]);
            ey[g*YW +: YW] = YW'(my[g]);
            ed[g*2 +: 2]   = 2'(md[g]);
            ec[g]          = (iabs(mx[g] - lat_px) < 16) && (iabs(my[g] - lat_py) < 16);
        end
        chk({tag, ".x"}, 64'(ghost_x), 64'(ex));
        chk({tag, ".y"}, 64'(ghost_y), 64'(ey));
        chk({tag, ".dir"}, 64'(ghost_dir), 64'(ed));
        chk({tag, ".collide"}, 64'(collide), 64'(ec));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Full sweep: tick, bounded observation window, latency and model checks.
    // inj>0 raises a stray tick while busy; scramble changes player inputs mid-sweep.
    task automatic run_sweep(input string tag, input bit fl, input int px, input int py,
                             input int inj, input bit scramble);
        int busy_cnt, done_cnt, done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        flee = fl; player_x = XW'(px); player_y = YW'(py); tick = 1'b1;
        lat_px = px; lat_py = py;
        model_sweep(fl, px, py);
        @(posedge clk); #1;
        tick = 1'b0;
        for (int c = 1; c <= NG + 3; c++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            tick = (c == inj);
            if (scramble) begin
                flee     = 1'($urandom);
                player_x = XW'($urandom);
                player_y = YW'($urandom);
            end
            @(posedge clk); #1;
        end
        tick = 1'b0;
        chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(NG + 1));
        chk({tag, ".done_cycle"}, 64'(done_at), 64'(NG + 1));
        chk({tag, ".done_pulses"}, 64'(done_cnt), 64'(1));
        chk_model(tag);
    endtask

    task automatic set_wall(input int r, input int c);
        walls[r*TC + c] = 1'b1;
    endtask

    // Steer ghost 0 from home to (288,224) heading right.
    task automatic setup_right();
        walls = '0;
        set_wall(13, 17);
        set_wall(14, 16);
        do_reset();
        for (int i = 0; i < 16; i++) run_sweep("setup", 1'b0, 272, 400, 0, 1'b0);
        chk("setup.x0", 64'(ghost_x[XW-1:0]), 64'(288));
        chk("setup.dir0", 64'(ghost_dir[1:0]), 64'(3));
    endtask

    initial begin
        col_vec_t         vecs [12];
        logic [NG*XW-1:0] home_x;
        logic [NG*YW-1:0] home_y;
        int               px, py, g;

        vecs[0]  = '{272, 224, 4'b0001};
        vecs[1]  = '{287, 224, 4'b0001};
        vecs[2]  = '{288, 224, 4'b0000};
        vecs[3]  = '{257, 209, 4'b0001};
        vecs[4]  = '{256, 224, 4'b0000};
        vecs[5]  = '{319, 224, 4'b0010};
        vecs[6]  = '{320, 224, 4'b0000};
        vecs[7]  = '{360, 239, 4'b1000};
        vecs[8]  = '{328, 230, 4'b0100};
        vecs[9]  = '{368, 240, 4'b0000};
        vecs[10] = '{257, 239, 4'b0001};
        vecs[11] = '{0,   0,   4'b0000};
        home_x = {10'd368, 10'd336, 10'd304, 10'd272};
        home_y = {4{9'd224}};

        reset = 1'b1; tick = 1'b0; flee = 1'b0;
        player_x = '0; player_y = '0; walls = '0;
        #12;
        do_reset();

        // Reset state
        chk("reset.x", 64'(ghost_x), 64'(home_x));
        chk("reset.y", 64'(ghost_y), 64'(home_y));
        chk("reset.dir", 64'(ghost_dir), 64'(0));
        chk("reset.collide", 64'(collide), 64'(0));
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.done", 64'(done), 64'(0));

        // Collision table with every ghost boxed in at home
        walls = '0;
        for (int k = 0; k < NG; k++) begin
            set_wall(13, 17 + 2*k);
            set_wall(15, 17 + 2*k);
            set_wall(14, 16 + 2*k);
            set_wall(14, 18 + 2*k);
        end
        do_reset();
        for (int i = 0; i < 12; i++) begin
            run_sweep("colvec", 1'b0, vecs[i].px, vecs[i].py, 0, 1'b0);
            chk($sformatf("colvec[%0d]", i), 64'(collide), 64'(vecs[i].exp_col));
        end
        chk("boxed.x", 64'(ghost_x), 64'(home_x));
        chk("boxed.dir0", 64'(ghost_dir[1:0]), 64'(0));

        // Dead end: only the reverse is open, then a mid-tile step
        walls = '0;
        set_wall(13, 17);
        set_wall(14, 16);
        set_wall(14, 18);
        do_reset();
        run_sweep("deadend", 1'b0, 272, 400, 0, 1'b0);
        chk("deadend.x0", 64'(ghost_x[XW-1:0]), 64'(272));
        chk("deadend.y0", 64'(ghost_y[YW-1:0]), 64'(225));
        chk("deadend.dir0", 64'(ghost_dir[1:0]), 64'(1));
        run_sweep("midtile", 1'b0, 272, 400, 0, 1'b0);
        chk("midtile.y0", 64'(ghost_y[YW-1:0]), 64'(226));
        chk("midtile.dir0", 64'(ghost_dir[1:0]), 64'(1));

        // Chase with right and up walled
        setup_right();
        set_wall(14, 19);
        set_wall(13, 18);
        run_sweep("chase", 1'b0, 288, 384, 0, 1'b0);
        chk("chase.y0", 64'(ghost_y[YW-1:0]), 64'(225));
        chk("chase.dir0", 64'(ghost_dir[1:0]), 64'(1));

        // Flee, down is the only choice
        setup_right();
        set_wall(14, 19);
        set_wall(13, 18);
        run_sweep("flee1", 1'b1, 288, 384, 0, 1'b0);
        chk("flee1.dir0", 64'(ghost_dir[1:0]), 64'(1));

        // Flee with up open: up is farther from the player
        setup_right();
        set_wall(14, 19);
        run_sweep("flee2", 1'b1, 288, 384, 0, 1'b0);
        chk("flee2.y0", 64'(ghost_y[YW-1:0]), 64'(223));
        chk("flee2.dir0", 64'(ghost_dir[1:0]), 64'(0));

        // Tick on the cycle after a tick is ignored
        walls = '0;
        do_reset();
        run_sweep("dbltick", 1'b0, 100, 100, 1, 1'b0);

        // Reset during EVAL of ghost 2
        run_sweep("pre_rst", 1'b0, 500, 400, 0, 1'b0);
        player_x = XW'(500); player_y = YW'(400); tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midrst.x", 64'(ghost_x), 64'(home_x));
        chk("midrst.y", 64'(ghost_y), 64'(home_y));
        chk("midrst.dir", 64'(ghost_dir), 64'(0));
        chk("midrst.busy", 64'(busy), 64'(0));
        chk("midrst.done", 64'(done), 64'(0));
        @(posedge clk); #1;
        chk("midrst.busy_next", 64'(busy), 64'(0));
        chk("midrst.x_next", 64'(ghost_x), 64'(home_x));
        reset = 1'b0;
        model_reset();
        run_sweep("post_rst", 1'b0, 500, 400, 0, 1'b0);

        // Random sweeps against the reference model
        for (int i = 0; i < 250; i++) begin
            if (i % 25 == 0) begin
                for (int b = 0; b < TR*TC; b++) walls[b] = ($urandom_range(0, 5) == 0);
                if (i == 0) do_reset();
            end
            if ($urandom_range(0, 2) == 0) begin
                g  = $urandom_range(0, NG - 1);
                px = mx[g] + $urandom_range(0, 40) - 20;
                py = my[g] + $urandom_range(0, 40) - 20;
                if (px < 0) px = 0;
                if (px > 639) px = 639;
                if (py < 0) py = 0;
                if (py > 479) py = 479;
            end else begin
                px = $urandom_range(0, 639);
                py = $urandom_range(0, 479);
            end
            run_sweep("rand", 1'($urandom), px, py, $urandom_range(0, NG), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
